permutation_controller: RTL
===========================

// Module: permutation_controller
// PURPOSE
//  Sequences the ASCON permutation datapath (constant addition, substitution, linear diffusion).
//  Accepts a start request.
//  Runs either p^a (12 rounds) or p^b (6 rounds), one round per clock cycle.
//  Generates the round index and round constant for each round.
//  Drives the input-state mux select and the state-register enable.
//  Signals completion with a one-cycle done pulse.
//  Sits between the mode FSM and the round datapath.
// PARAMETERS
//  NB_ROUNDS_A  12  rounds of p^a; the last round index is always 11
//  NB_ROUNDS_B  6   rounds of p^b; p^b starts at round index 12-NB_ROUNDS_B
//  CNT_W        4   width of the round counter
// PORTS
//  clock_i     in   1      single clock, rising edge
//  reset_i     in   1      synchronous reset, active-high
//  start_i     in   1      permutation request; accepted only when start_i & ready_o
//  mode_i      in   1      0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled on accept
//  ready_o     out  1      1 in IDLE only
//  round_o     out  CNT_W  current round index (0..11)
//  const_o     out  8      round constant {4'hF-round_o, round_o}
//  init_sel_o  out  1      1: datapath takes the external state; 0: the fed-back state
//  state_en_o  out  1      state register load enable
//  done_o      out  1      one-cycle pulse after the last round is loaded
// BEHAVIOUR
//  - Reset: reset_i sampled high forces IDLE and round counter 0.
//    - Reset values: ready_o=1, round_o=0, const_o=8'h00, init_sel_o=0, state_en_o=0, done_o=0.
//    - Reset wins over start_i in the same cycle.
//  - FSM states are IDLE, FIRST, RUN and DONE. All outputs are decoded from registered state (Moore).
//  - IDLE: on start_i=1, go to FIRST.
//    - Load the counter with 0 (mode_i=0) or 12-NB_ROUNDS_B (mode_i=1).
//    - start_i=0: stay in IDLE.
//  - FIRST: lasts one cycle.
//    - init_sel_o=1, state_en_o=1, const_o valid for the start round.
//    - Counter increments. Next state is RUN.
//  - RUN: init_sel_o=0, state_en_o=1, counter increments each cycle.
//    - When round_o==11 the next state is DONE and the counter is held.
//  - DONE: lasts one cycle.
//    - done_o=1, state_en_o=0, round_o holds 11.
//    - Next state is IDLE and the counter clears to 0.
//  - FIRST->DONE cannot occur because both parameters are at least 2.
//  - const_o=8'h00 outside FIRST/RUN.
//  - Latency (accept at cycle T):
//    - p^a: state loaded at T+1..T+12, done_o at T+13, ready_o=1 at T+14.
//    - p^b: state loaded at T+1..T+6, done_o at T+7, ready_o=1 at T+8.
//  - start_i and mode_i are ignored outside IDLE. No queuing.
//  - mode_i changes after accept have no effect.
//  - Reset asserted in FIRST, RUN or DONE:
//    - Next cycle is IDLE with reset values.
//    - No done_o pulse for the aborted permutation.
//  - Counter never exceeds 11; no wrap-around occurs.
// CONFIGURATION
//  - Macro PERM_CTRL_COUNT_EN defined:
//    - Adds output port perm_count_o (16 bits).
//    - perm_count_o increments by 1 in each DONE cycle, 16'hFFFF wraps to 16'h0000.
//    - Reset value is 0.
//  - Macro not defined: no perm_count_o port and no counter logic. All other behaviour is identical.
// TESTING
//  1. Reset held 2 cycles, then released.
//     -> ready_o=1, round_o=0, const_o=00, state_en_o=0, done_o=0.
//  2. start_i=1, mode_i=0 at T.
//     -> const_o F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B at T+1..T+12.
//     -> init_sel_o=1 only at T+1; done_o at T+13; ready_o at T+14.
//  3. start_i=1, mode_i=1 at T.
//     -> const_o 96,87,78,69,5A,4B at T+1..T+6; done_o at T+7.
//  4. start_i held high continuously, mode_i toggling.
//     -> new permutation accepted only in IDLE cycles; first mode sampled is used.
//  5. reset_i pulsed at round 5 of p^a.
//     -> IDLE next cycle, no done_o pulse; a new p^b then runs correctly.
//  6. PERM_CTRL_COUNT_EN defined, perm_count_o forced near 16'hFFFF, 3 permutations run.
//     -> perm_count_o reads FFFF, then 0000, then 0001.

Source files
------------

// File: rtl/permutation_controller.sv
// Round sequencer for the ASCON permutation: runs p^a (12 rounds) or p^b (6 rounds),
// one round per cycle. Optional macro PERM_CTRL_COUNT_EN adds a completed-permutation counter.
module permutation_controller #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6,
    parameter int CNT_W       = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             ready_o,
    output logic [CNT_W-1:0] round_o,
    output logic [7:0]       const_o,
    output logic             init_sel_o,
    output logic             state_en_o,
    output logic             done_o
`ifdef PERM_CTRL_COUNT_EN
    ,
    output logic [15:0]      perm_count_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // p^b shares the tail of the p^a constant schedule, so both end on the same round.
    localparam logic [CNT_W-1:0] LAST_ROUND  = CNT_W'(NB_ROUNDS_A - 1);
    localparam logic [CNT_W-1:0] START_B     = CNT_W'(NB_ROUNDS_A - NB_ROUNDS_B);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [3:0]       round_lo;
    logic             running;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                round_d = '0;
                if (start_i) begin
                    state_d = S_FIRST;
                    round_d = mode_i ? START_B : '0;
                end
            end
            S_FIRST: begin
                state_d = S_RUN;
                round_d = round_q + 1'b1;
            end
            S_RUN: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign running    = (state_q == S_FIRST) || (state_q == S_RUN);
    assign round_lo   = 4'(round_q);
    assign ready_o    = (state_q == S_IDLE);
    assign round_o    = round_q;
    assign const_o    = running ? {4'hF - round_lo, round_lo} : 8'h00;
    assign init_sel_o = (state_q == S_FIRST);
    assign state_en_o = running;
    assign done_o     = (state_q == S_DONE);

`ifdef PERM_CTRL_COUNT_EN
    logic [15:0] perm_count_q, perm_count_d;

    always_comb begin
        perm_count_d = perm_count_q;
        if (state_q == S_DONE) begin
            perm_count_d = perm_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perm_count_q <= 16'd0;
        end else begin
            perm_count_q <= perm_count_d;
        end
    end

    assign perm_count_o = perm_count_q;
`endif

endmodule
